// File: rtl/srpt_grant_pkts.sv
// Receiver-side SRPT grant scheduler: keeps a shortest-remaining-first RPC table
// fed by packet headers and issues grants for the OVERCOMMIT shortest RPCs.
module srpt_grant_pkts #(
  parameter int DEPTH      = 8,
  parameter int OVERCOMMIT = 2,
  parameter int WINDOW     = 64
) (
  input  logic        ap_clk,
  input  logic        ap_rst,
  input  logic        ap_ce,
  input  logic        ap_start,
  input  logic        ap_continue,
  input  logic        header_in_empty_i,
  output logic        header_in_read_en_o,
  input  logic [57:0] header_in_data_i,
  input  logic        grant_pkt_full_o,
  output logic        grant_pkt_write_en_o,
  output logic [50:0] grant_pkt_data_o,
  output logic        ap_idle,
  output logic        ap_done,
  output logic        ap_ready
);

  localparam int IW = $clog2(DEPTH);

  typedef struct packed {
    logic        valid;
    logic [13:0] peer;
    logic [13:0] rpc;
    logic [9:0]  len;
    logic [9:0]  recv;
    logic [9:0]  granted;
  } entry_t;

  typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_SORT} state_t;

  state_t        state_q, state_d;
  entry_t        tab_q [DEPTH];
  entry_t        tab_d [DEPTH];
  logic [57:0]   hdr_q, hdr_d;
  logic [IW-1:0] pos_q, pos_d;
  logic          sort_q, sort_d;
  logic          idle_q, idle_d;
  logic          done_q, done_d;

  logic          running, pop, push;
  logic [50:0]   pkt;
  logic          gnt_hit;
  logic [IW-1:0] gnt_idx;
  logic [10:0]   gnt_lim, lim_i;
  logic          hit;
  logic [IW-1:0] hit_idx, free_idx, dst;
  logic [9:0]    new_recv, key;
  entry_t        fresh;
  logic          unused_bits;

  logic [13:0]   h_peer, h_rpc;
  logic [9:0]    h_len, h_off;

  assign h_peer = hdr_q[57:44];
  assign h_rpc  = hdr_q[43:30];
  assign h_len  = hdr_q[29:20];
  assign h_off  = hdr_q[9:0];
  assign unused_bits = ^{ap_continue, hdr_q[19:10]};

  // Clock enable gates the run condition, so every strobe drops while frozen.
  assign running = ap_ce & ap_start & ~idle_q;

  // Lowest head index whose grant lags min(msg_len, recv+WINDOW).
  always_comb begin
    gnt_hit = 1'b0;
    gnt_idx = '0;
    gnt_lim = '0;
    lim_i   = '0;
    for (int i = OVERCOMMIT - 1; i >= 0; i--) begin
      lim_i = ({1'b0, tab_q[i].len} < ({1'b0, tab_q[i].recv} + 11'(WINDOW)))
            ? {1'b0, tab_q[i].len} : ({1'b0, tab_q[i].recv} + 11'(WINDOW));
      if (tab_q[i].valid && ({1'b0, tab_q[i].granted} < lim_i)) begin
        gnt_hit = 1'b1;
        gnt_idx = IW'(i);
        gnt_lim = lim_i;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    tab_d    = tab_q;
    hdr_d    = hdr_q;
    pos_d    = pos_q;
    sort_d   = sort_q;
    idle_d   = ~ap_start;
    pop      = 1'b0;
    push     = 1'b0;
    pkt      = '0;
    fresh    = {1'b1, h_peer, h_rpc, h_len, h_off, h_off};

    hit      = 1'b0;
    hit_idx  = '0;
    free_idx = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (tab_q[k].valid && tab_q[k].peer == h_peer && tab_q[k].rpc == h_rpc) begin
        hit     = 1'b1;
        hit_idx = IW'(k);
      end
      if (!tab_q[k].valid) free_idx = IW'(k);
    end
    new_recv = (h_off > tab_q[hit_idx].recv) ? h_off : tab_q[hit_idx].recv;

    // Insertion point: after every earlier entry with remaining <= the moved one.
    key = tab_q[pos_q].len - tab_q[pos_q].recv;
    dst = '0;
    for (int j = 0; j < DEPTH; j++) begin
      if (IW'(j) < pos_q && (tab_q[j].len - tab_q[j].recv) <= key) dst = dst + IW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (running && !header_in_empty_i) begin
          pop     = 1'b1;
          hdr_d   = header_in_data_i;
          state_d = S_UPDATE;
        end else if (running && !grant_pkt_full_o && gnt_hit) begin
          push = 1'b1;
          pkt  = {tab_q[gnt_idx].peer, tab_q[gnt_idx].rpc, gnt_lim[9:0],
                  tab_q[gnt_idx].len, 3'(7 - int'(gnt_idx))};
          tab_d[gnt_idx].granted = gnt_lim[9:0];
        end
      end
      S_UPDATE: begin
        sort_d  = 1'b0;
        state_d = S_SORT;
        if (hit) begin
          if (tab_q[hit_idx].len <= new_recv) begin
            for (int k = 0; k < DEPTH; k++) begin
              if (IW'(k) >= hit_idx)
                tab_d[k] = (k < DEPTH - 1) ? tab_q[(k < DEPTH - 1) ? k + 1 : k] : entry_t'('0);
            end
          end else begin
            tab_d[hit_idx].recv = new_recv;
            pos_d  = hit_idx;
            sort_d = 1'b1;
          end
        end else if (h_len > h_off) begin
          if (!tab_q[DEPTH-1].valid) begin
            tab_d[free_idx] = fresh;
            pos_d  = free_idx;
            sort_d = 1'b1;
          end else if ((h_len - h_off) < (tab_q[DEPTH-1].len - tab_q[DEPTH-1].recv)) begin
            tab_d[DEPTH-1] = fresh;
            pos_d  = IW'(DEPTH - 1);
            sort_d = 1'b1;
          end
        end
      end
      S_SORT: begin
        state_d = S_IDLE;
        if (sort_q) begin
          for (int k = 0; k < DEPTH; k++) begin
            if (IW'(k) == dst)
              tab_d[k] = tab_q[pos_q];
            else if (IW'(k) > dst && IW'(k) <= pos_q)
              tab_d[k] = tab_q[(k > 0) ? k - 1 : 0];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    done_d = pop;
  end

  always_ff @(posedge ap_clk or negedge ap_rst) begin
    if (!ap_rst) begin
      state_q <= S_IDLE;
      for (int k = 0; k < DEPTH; k++) tab_q[k] <= '0;
      hdr_q   <= '0;
      pos_q   <= '0;
      sort_q  <= 1'b0;
      idle_q  <= 1'b1;
      done_q  <= 1'b0;
    end else if (ap_ce) begin
      state_q <= state_d;
      for (int k = 0; k < DEPTH; k++) tab_q[k] <= tab_d[k];
      hdr_q   <= hdr_d;
      pos_q   <= pos_d;
      sort_q  <= sort_d;
      idle_q  <= idle_d;
      done_q  <= done_d;
    end
  end

  assign header_in_read_en_o  = pop;
  assign grant_pkt_write_en_o = push;
  assign grant_pkt_data_o     = pkt;
  assign ap_idle              = idle_q;
  assign ap_done              = done_q & ap_ce;
  assign ap_ready             = done_q & ap_ce;

endmodule

// File: tb/tb_srpt_grant_pkts.sv
// Self-checking bench for srpt_grant_pkts: directed scenarios plus randomized
// headers compared against a queue-based SRPT reference model.
module tb_srpt_grant_pkts;

  logic        ap_clk = 1'b0;
  logic        ap_rst, ap_ce, ap_start, ap_continue;
  logic        header_in_empty_i, header_in_read_en_o;
  logic [57:0] header_in_data_i;
  logic        grant_pkt_full_o, grant_pkt_write_en_o;
  logic [50:0] grant_pkt_data_o;
  logic        ap_idle, ap_done, ap_ready;

  typedef struct {
    int peer;
    int rpc;
    int len;
    int recv;
    int granted;
  } ment_t;

  ment_t       mq[$];
  logic [57:0] fifo_q[$];
  logic [50:0] got_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          pop_cnt  = 0;
  int          done_cnt = 0;
  int          rdy_cnt  = 0;
  int          len_tab[12];

  always #5 ap_clk = ~ap_clk;

  srpt_grant_pkts dut (
    .ap_clk               (ap_clk),
    .ap_rst               (ap_rst),
    .ap_ce                (ap_ce),
    .ap_start             (ap_start),
    .ap_continue          (ap_continue),
    .header_in_empty_i    (header_in_empty_i),
    .header_in_read_en_o  (header_in_read_en_o),
    .header_in_data_i     (header_in_data_i),
    .grant_pkt_full_o     (grant_pkt_full_o),
    .grant_pkt_write_en_o (grant_pkt_write_en_o),
    .grant_pkt_data_o     (grant_pkt_data_o),
    .ap_idle              (ap_idle),
    .ap_done              (ap_done),
    .ap_ready             (ap_ready)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [50:0] mkGrant(int peer, int rpc, int off, int len, int pri);
    return {14'(peer), 14'(rpc), 10'(off), 10'(len), 3'(pri)};
  endfunction

  task automatic refreshInputs();
    header_in_empty_i = (fifo_q.size() == 0);
    header_in_data_i  = (fifo_q.size() == 0) ? 58'd0 : fifo_q[0];
  endtask

  // One clock: sample DUT at negedge, then advance the FIFO just after posedge.
  task automatic tick();
    logic popped;
    @(negedge ap_clk);
    popped = header_in_read_en_o;
    if (popped) begin
      pop_cnt++;
      checkOutput("pop_only_when_nonempty", header_in_empty_i, 0);
    end
    if (grant_pkt_write_en_o) begin
      got_q.push_back(grant_pkt_data_o);
      checkOutput("no_push_when_full", grant_pkt_full_o, 0);
    end
    if (ap_done) done_cnt++;
    if (ap_ready) rdy_cnt++;
    @(posedge ap_clk);
    #1;
    if (popped && fifo_q.size() > 0) void'(fifo_q.pop_front());
    refreshInputs();
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic int rem(ment_t e);
    return e.len - e.recv;
  endfunction

  // Stable sort by remaining bytes: equal keys keep their relative order.
  task automatic modelSort();
    for (int i = 1; i < mq.size(); i++) begin
      ment_t tmp;
      int    j;
      tmp = mq[i];
      j   = i - 1;
      while (j >= 0 && rem(mq[j]) > rem(tmp)) begin
        mq[j+1] = mq[j];
        j--;
      end
      mq[j+1] = tmp;
    end
  endtask

  task automatic modelHeader(int peer, int rpc, int len, int off);
    int    idx;
    ment_t e;
    idx = -1;
    foreach (mq[i]) if (mq[i].peer == peer && mq[i].rpc == rpc) idx = i;
    if (idx >= 0) begin
      if (off > mq[idx].recv) mq[idx].recv = off;
      if (mq[idx].len <= mq[idx].recv) mq.delete(idx);
      else modelSort();
    end else if (len > off) begin
      e = '{peer: peer, rpc: rpc, len: len, recv: off, granted: off};
      if (mq.size() < 8) begin
        mq.push_back(e);
        modelSort();
      end else if ((len - off) < rem(mq[mq.size()-1])) begin
        mq[mq.size()-1] = e;
        modelSort();
      end
    end
  endtask

  task automatic applyStimulus(int peer, int rpc, int len, int off);
    logic [9:0] junk;
    junk = 10'($urandom);
    fifo_q.push_back({14'(peer), 14'(rpc), 10'(len), junk, 10'(off)});
    refreshInputs();
    modelHeader(peer, rpc, len, off);
  endtask

  function automatic logic [50:0] gotAt(int i);
    if (i < got_q.size()) return got_q[i];
    return 'x;
  endfunction

  // Drain the model's grants and compare against everything the DUT pushed.
  task automatic compareGrants(input string tag);
    logic [50:0] exp_q[$];
    for (int n = 0; n < 64; n++) begin
      bit found;
      found = 0;
      for (int i = 0; i < 2 && i < mq.size(); i++) begin
        int lim;
        lim = (mq[i].len < mq[i].recv + 64) ? mq[i].len : mq[i].recv + 64;
        if (!found && mq[i].granted < lim) begin
          exp_q.push_back(mkGrant(mq[i].peer, mq[i].rpc, lim, mq[i].len, 7 - i));
          mq[i].granted = lim;
          found = 1;
        end
      end
      if (!found) break;
    end
    checkOutput({tag, "_count"}, got_q.size(), exp_q.size());
    foreach (exp_q[i]) checkOutput({tag, "_pkt"}, gotAt(i), exp_q[i]);
    got_q.delete();
  endtask

  initial begin
    int d0;

    // Reset state, with start asserted and a header apparently available.
    ap_rst = 1'b0;
    ap_ce = 1'b1;
    ap_start = 1'b1;
    ap_continue = 1'b0;
    header_in_empty_i = 1'b0;
    header_in_data_i = 58'h3ff_ffff;
    grant_pkt_full_o = 1'b0;
    #12;
    checkOutput("rst_read_en", header_in_read_en_o, 0);
    checkOutput("rst_write_en", grant_pkt_write_en_o, 0);
    checkOutput("rst_data", grant_pkt_data_o, 0);
    checkOutput("rst_idle", ap_idle, 1);
    checkOutput("rst_done", ap_done, 0);
    checkOutput("rst_ready", ap_ready, 0);
    @(posedge ap_clk);
    #1;
    ap_rst = 1'b1;
    refreshInputs();
    run(4);
    checkOutput("s1_no_pops", pop_cnt, 0);
    checkOutput("s1_no_grants", got_q.size(), 0);
    checkOutput("s1_no_done", done_cnt, 0);
    checkOutput("s1_idle_low", ap_idle, 0);

    // Two headers against a full grant FIFO; clock enable held low first.
    ap_ce = 1'b0;
    grant_pkt_full_o = 1'b1;
    applyStimulus(1, 1, 1, 0);
    applyStimulus(2, 2, 2, 0);
    run(4);
    checkOutput("s2_ce_freeze", pop_cnt, 0);
    ap_ce = 1'b1;
    run(8);
    checkOutput("s2_pops", pop_cnt, 2);
    checkOutput("s2_done", done_cnt, 2);
    checkOutput("s2_ready", rdy_cnt, 2);
    checkOutput("s2_no_grants", got_q.size(), 0);

    grant_pkt_full_o = 1'b0;
    run(6);
    checkOutput("s3_grant0", gotAt(0), mkGrant(1, 1, 1, 1, 7));
    checkOutput("s3_grant1", gotAt(1), mkGrant(2, 2, 2, 2, 6));
    compareGrants("s3");
    run(4);
    checkOutput("s3_no_more", got_q.size(), 0);

    applyStimulus(1, 1, 1, 1);
    run(8);
    compareGrants("s4");

    applyStimulus(3, 3, 500, 0);
    run(8);
    checkOutput("s5_grant64", gotAt(0), mkGrant(3, 3, 64, 500, 6));
    compareGrants("s5a");
    applyStimulus(3, 3, 500, 64);
    run(8);
    checkOutput("s5_grant128", gotAt(0), mkGrant(3, 3, 128, 500, 6));
    compareGrants("s5b");

    for (int k = 0; k < 6; k++) begin
      applyStimulus(10 + k, 10 + k, 600 + 10 * k, 0);
      run(6);
    end
    compareGrants("s6_fill");
    d0 = done_cnt;
    applyStimulus(20, 20, 1000, 0);
    run(8);
    checkOutput("s6_drop_done", done_cnt, d0 + 1);
    compareGrants("s6_drop");
    applyStimulus(21, 21, 100, 0);
    run(8);
    checkOutput("s6_evict_grant", gotAt(0), mkGrant(21, 21, 64, 100, 6));
    compareGrants("s6_evict");
    applyStimulus(15, 15, 650, 10);
    run(8);
    compareGrants("s6_tie_drop");

    // Reset while a header is mid-update: the table must come back empty.
    fifo_q.push_back({14'd30, 14'd30, 10'd50, 10'd0, 10'd0});
    refreshInputs();
    tick();
    ap_rst = 1'b0;
    #1;
    checkOutput("mid_rst_idle", ap_idle, 1);
    run(2);
    fifo_q.delete();
    mq.delete();
    got_q.delete();
    refreshInputs();
    ap_rst = 1'b1;
    applyStimulus(40, 40, 10, 0);
    run(8);
    checkOutput("mid_rst_fresh", gotAt(0), mkGrant(40, 40, 10, 10, 7));
    compareGrants("mid_rst");

    // Randomized headers over 12 RPCs so the table overflows and evicts.
    foreach (len_tab[i]) len_tab[i] = $urandom_range(20, 1000);
    for (int n = 0; n < 40; n++) begin
      int r, off;
      r = $urandom_range(0, 11);
      off = $urandom_range(0, len_tab[r]);
      if ($urandom_range(0, 7) == 0) off = len_tab[r];
      grant_pkt_full_o = 1'b1;
      applyStimulus(200 + r, 50 + r, len_tab[r], off);
      run(5);
      for (int c = 0; c < 20; c++) begin
        grant_pkt_full_o = $urandom_range(0, 1);
        tick();
      end
      grant_pkt_full_o = 1'b0;
      run(10);
      compareGrants("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
